acc_seq_ctrl: RTL
=================

# acc_seq_ctrl

Sequencing controller for the 8-bit accumulate datapath. It accepts a start command carrying an operand count and consumes exactly that many operands from a valid/ready stream. Each accepted operand is summed into a running signed total through the existing `adder_8bit`. On completion it presents the sum with sticky carry and overflow flags and a one-cycle done pulse. It sits between a command source (CPU/testbench sequencer) and the operand stream and replaces free-running accumulation with counted, framed accumulation.

## Interface
- `DW`, 8, operand/sum width (adder is fixed 8-bit; only 8 is legal)
- `CNT_W`, 4, width of operand count; max frame = 2^CNT_W-1 operands
- `i_clk`  in  1  clock, rising edge
- `ni_rst`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  start pulse; sampled only in IDLE
- `i_len`  in  CNT_W  operand count, captured with `i_start`
- `i_clear`  in  1  synchronous abort; highest priority after reset
- `i_valid`  in  1  operand valid
- `i_data`  in  DW  operand, two's complement
- `o_ready`  out  1  operand accepted when `i_valid & o_ready`
- `o_busy`  out  1  high in RUN and DONE
- `o_done`  out  1  one-cycle pulse, result valid
- `o_sum`  out  DW  running/final sum
- `o_carry`  out  1  sticky: unsigned carry-out on any add in frame
- `o_ovf`  out  1  sticky: signed overflow on any add in frame

## Operation
- States: IDLE, RUN, DONE (encoded in package enum).
- IDLE:
  - `o_ready`=0.
  - On `i_start`: capture `i_len` into `cnt` and clear `o_sum`/`o_carry`/`o_ovf` to 0.
  - Next state is RUN if `i_len`≠0, else DONE.
- RUN:
  - `o_ready`=1.
  - Per handshake: `o_sum` <= `o_sum` + `i_data` (adder, cin=0); `o_carry` |= carry; `o_ovf` |= ovf; `cnt` decrements.
  - Handshake with `cnt`==1 → DONE.
  - No handshake → stay in RUN; sum and flags hold.
- DONE: `o_done`=1 for exactly this cycle → IDLE.
- `o_sum`/flags hold after DONE until the next accepted `i_start`.
- `i_start` in RUN/DONE: ignored; no queuing.
- `i_clear` (any state): → IDLE; `cnt`, `o_sum`, flags cleared; no `o_done`; a concurrent handshake is discarded.
- `i_clear` and `i_start` in the same IDLE cycle: clear wins, start dropped.
- Arithmetic: modulo 2^8 wraparound. Overflow uses the standard signed rule (operands same sign, result sign differs).

## Timing
- Reset values: state IDLE, `cnt`=0; `o_ready`, `o_busy`, `o_done`, `o_carry`, `o_ovf` = 0; `o_sum`=0.
- Asynchronous reset mid-frame aborts immediately to the reset values; no `o_done`.
- `o_ready`, `o_busy`, `o_done` decode from registered state only; no combinational path from inputs.
- Start accepted at edge k → RUN from k+1; first operand accepted at earliest on edge k+1.
- N back-to-back operands: last handshake at edge k+N; DONE (with final `o_sum`) during cycle k+N+1.
- Frame latency = N+1 cycles after start edge minimum; `i_valid` gaps extend RUN one cycle per gap.
- `i_len`=0: DONE in cycle k+1 with `o_sum`=0 and flags 0.
- Next start accepted earliest in the cycle after DONE (IDLE), i.e. one bubble between frames.

## Structure
- Package `acc_pkg`:
  - `DW` constant
  - `acc_state_e` enum {IDLE, RUN, DONE}
- Sub-module: one `adder_8bit` instance.
  - Inputs: `i_a`=`i_data`, `i_b`=`o_sum`, `i_cin`=0.
  - Outputs: `o_sum`/`o_carry`/`o_ovf` feed the next-state sum and flag logic.
- Remaining logic (FSM, down-counter, sticky flags) stays local.

## Test plan
- Reset with inputs toggling → all outputs 0, `o_ready`=0; release → stays IDLE.
- `i_start`, `i_len`=3, operands 10,20,30 back-to-back → `o_done` pulse one cycle after third handshake; `o_sum`=60, carry 0, ovf 0.
- `i_len`=2, operands 100,50 → `o_sum`=0x96, `o_ovf`=1, `o_carry`=0.
- `i_len`=2, operands 0xFF,0x02 → `o_sum`=0x01, `o_carry`=1, `o_ovf`=0.
- `i_len`=3 with `i_valid` gaps, and `i_start` pulsed mid-frame:
  - Frame completes after exactly 3 handshakes; second start ignored.
  - `i_len`=0 → `o_done` one cycle after start, `o_sum`=0.
- Abort cases:
  - `i_clear` after 1 of 4 operands → IDLE next cycle, `o_sum`=0, no `o_done`.
  - `ni_rst` low mid-frame → immediate reset values.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared constants and state encoding for the counted accumulate controller.
package acc_pkg;

    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } acc_state_e;

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// Command/operand stream and result bus between the sequencer and the controller.
interface acc_seq_ctrl_if
    import acc_pkg::*;
#(
    parameter int CNT_W = 4
);

    logic             i_start;
    logic [CNT_W-1:0] i_len;
    logic             i_clear;
    logic             i_valid;
    logic [DW-1:0]    i_data;
    logic             o_ready;
    logic             o_busy;
    logic             o_done;
    logic [DW-1:0]    o_sum;
    logic             o_carry;
    logic             o_ovf;

    modport master (
        output i_start, i_len, i_clear, i_valid, i_data,
        input  o_ready, o_busy, o_done, o_sum, o_carry, o_ovf
    );

    modport slave (
        input  i_start, i_len, i_clear, i_valid, i_data,
        output o_ready, o_busy, o_done, o_sum, o_carry, o_ovf
    );

endinterface

// File: rtl/adder_8bit.sv
// 8-bit ripple adder with unsigned carry-out and signed overflow detection.
module adder_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_carry,
    output logic       o_ovf
);

    logic [8:0] full;

    always_comb begin
        full    = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
        o_sum   = full[7:0];
        o_carry = full[8];
        // Signed overflow: both operands share a sign the result does not.
        o_ovf   = (i_a[7] == i_b[7]) && (full[7] != i_a[7]);
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Framed accumulator: takes a counted start, sums that many stream operands, pulses done.
module acc_seq_ctrl
    import acc_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic           i_clk,
    input  logic           ni_rst,
    acc_seq_ctrl_if.slave  bus
);

    acc_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    sum;
    logic             carry;
    logic             ovf;
    logic             ready;
    logic             busy;
    logic             done;

    logic [DW-1:0]    add_sum;
    logic             add_carry;
    logic             add_ovf;

    adder_8bit u_adder (
        .i_a     (bus.i_data),
        .i_b     (sum),
        .i_cin   (1'b0),
        .o_sum   (add_sum),
        .o_carry (add_carry),
        .o_ovf   (add_ovf)
    );

    // Handshake flags are registered alongside the state so they never see input paths.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state <= IDLE;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (bus.i_clear) begin
            state <= IDLE;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        cnt   <= bus.i_len;
                        sum   <= '0;
                        carry <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        if (bus.i_len != '0) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.i_valid) begin
                        sum   <= add_sum;
                        carry <= carry | add_carry;
                        ovf   <= ovf | add_ovf;
                        cnt   <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            ready <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_busy  = busy;
    assign bus.o_done  = done;
    assign bus.o_sum   = sum;
    assign bus.o_carry = carry;
    assign bus.o_ovf   = ovf;

endmodule
